// File: rtl/race_pkg.sv
// race_pkg
// Shared definitions for the drag-racing game controller: the FSM state
// encoding, the PS/2 scan codes the controller reacts to, and a small
// saturating helper used by the speed integrator.
package race_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_RACE      = 2'd2,
      ST_FINISH    = 2'd3
   } race_state_t;

   localparam logic [7:0] KEY_BREAK = 8'hF0;
   localparam logic [7:0] KEY_W     = 8'h1D;
   localparam logic [7:0] KEY_SPACE = 8'h29;

   // Moves a 4-bit speed one step up or down, pinned to [0, max_val].
   function automatic logic [3:0] speed_step(input logic [3:0] cur,
                                             input logic       up,
                                             input logic [3:0] max_val);
      logic [3:0] result;
      result = cur;
      if (up) begin
         if (cur < max_val) begin
            result = cur + 4'd1;
         end
      end else begin
         if (cur != 4'd0) begin
            result = cur - 4'd1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/race_key_tracker.sv
// race_key_tracker
// Turns the raw PS/2 scan-code stream into the two controls the game uses:
// a level "throttle" flag that follows the W key, and a one-cycle
// "space_press" event for Space make codes.
// Ports:
//   clk, rst     : pixel clock, synchronous active-high reset
//   key_valid    : one-cycle strobe accompanying key_code
//   key_code     : PS/2 scan code
//   throttle     : registered, 1 while W is held
//   space_press  : combinational, same cycle as the Space make strobe
module race_key_tracker
   import race_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic       throttle,
   output logic       space_press
);

   logic brk_q;
   logic throttle_q;

   // A break prefix (F0) marks the following code as a key release. Any
   // non-prefix code consumes the prefix, so the flag only ever covers the
   // single code that follows it. W make/break sets/clears the throttle.
   always_ff @(posedge clk) begin
      if (rst) begin
         brk_q      <= 1'b0;
         throttle_q <= 1'b0;
      end else if (key_valid) begin
         if (key_code == KEY_BREAK) begin
            brk_q <= 1'b1;
         end else begin
            brk_q <= 1'b0;
            if (key_code == KEY_W) begin
               throttle_q <= ~brk_q;
            end
         end
      end
   end

   // Space is left combinational so the FSM can change state on the very
   // edge that carries the strobe.
   always_comb begin
      throttle    = throttle_q;
      space_press = key_valid && (key_code == KEY_SPACE) && !brk_q;
   end

endmodule

// File: rtl/race_ctrl.sv
// race_ctrl
// Frame-synchronous game controller for Drag-Racing. Runs the
// IDLE -> COUNTDOWN -> RACE -> FINISH sequence, integrates throttle into
// speed and position once per frame, and feeds draw_car plus the HUD.
// Ports:
//   clk, rst     : 65 MHz pixel clock, synchronous active-high reset
//   vsync_in     : vertical sync; its rising edge is the frame tick
//   key_valid    : one-cycle strobe, new scan code on key_code
//   key_code     : PS/2 scan code
//   car_xpos     : car x position (12 bit)
//   car_ypos     : car y position, constant CAR_Y
//   car_mov      : 1 while racing with nonzero speed
//   state        : 0 IDLE, 1 COUNTDOWN, 2 RACE, 3 FINISH
//   countdown    : lights remaining 3..1, 0 outside COUNTDOWN
//   speed        : current speed, px/frame
//   race_time    : frames elapsed in RACE, saturating
//   false_start  : throttle was held when a countdown frame ticked
module race_ctrl
   import race_pkg::*;
#(
   parameter int START_X      = 256,
   parameter int FINISH_X     = 960,
   parameter int CAR_Y        = 400,
   parameter int COUNT_FRAMES = 60,
   parameter int ACCEL_DIV    = 4,
   parameter int SPEED_MAX    = 15
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic [11:0] car_xpos,
   output logic [11:0] car_ypos,
   output logic        car_mov,
   output logic [1:0]  state,
   output logic [1:0]  countdown,
   output logic [3:0]  speed,
   output logic [15:0] race_time,
   output logic        false_start
);

   localparam logic [11:0] START_POS  = 12'(START_X);
   localparam logic [12:0] FINISH_POS = 13'(FINISH_X);
   localparam logic [11:0] CAR_ROW    = 12'(CAR_Y);
   localparam logic [15:0] FRAME_LAST = 16'(COUNT_FRAMES - 1);
   localparam logic [15:0] ACCEL_LAST = 16'(ACCEL_DIV - 1);
   localparam logic [3:0]  SPD_MAX    = 4'(SPEED_MAX);

   logic        throttle;
   logic        space_press;
   logic        vsync_q;
   logic        tick;
   logic [12:0] pos_sum;

   race_state_t state_q,     state_n;
   logic [11:0] xpos_q,      xpos_n;
   logic [3:0]  speed_q,     speed_n;
   logic [15:0] time_q,      time_n;
   logic [1:0]  cd_q,        cd_n;
   logic        fs_q,        fs_n;
   logic        mov_q,       mov_n;
   logic [15:0] frame_q,     frame_n;
   logic [15:0] accel_q,     accel_n;

   race_key_tracker u_keys (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .throttle    (throttle),
      .space_press (space_press)
   );

   assign tick = vsync_in & ~vsync_q;

   // State register: the FSM state, every registered output and the frame
   // and acceleration counters all load together so a reset in any state
   // lands the whole controller back at the start line.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q <= 1'b0;
         state_q <= ST_IDLE;
         xpos_q  <= START_POS;
         speed_q <= 4'd0;
         time_q  <= 16'd0;
         cd_q    <= 2'd0;
         fs_q    <= 1'b0;
         mov_q   <= 1'b0;
         frame_q <= 16'd0;
         accel_q <= 16'd0;
      end else begin
         vsync_q <= vsync_in;
         state_q <= state_n;
         xpos_q  <= xpos_n;
         speed_q <= speed_n;
         time_q  <= time_n;
         cd_q    <= cd_n;
         fs_q    <= fs_n;
         mov_q   <= mov_n;
         frame_q <= frame_n;
         accel_q <= accel_n;
      end
   end

   // Next-state logic. Ticks read the registered throttle, so a key arriving
   // on the same edge as a tick only affects the following frame. Position
   // is summed in 13 bits so the finish clamp catches the overshoot before
   // it could wrap the 12-bit coordinate.
   always_comb begin
      state_n = state_q;
      xpos_n  = xpos_q;
      speed_n = speed_q;
      time_n  = time_q;
      cd_n    = cd_q;
      fs_n    = fs_q;
      frame_n = frame_q;
      accel_n = accel_q;
      pos_sum = {1'b0, xpos_q} + {9'd0, speed_q};

      case (state_q)
         ST_IDLE: begin
            if (space_press) begin
               state_n = ST_COUNTDOWN;
               cd_n    = 2'd3;
               frame_n = 16'd0;
            end
         end

         ST_COUNTDOWN: begin
            if (tick) begin
               if (throttle) begin
                  fs_n    = 1'b1;
                  cd_n    = 2'd0;
                  state_n = ST_FINISH;
               end else if (frame_q == FRAME_LAST) begin
                  frame_n = 16'd0;
                  cd_n    = cd_q - 2'd1;
                  if (cd_q == 2'd1) begin
                     state_n = ST_RACE;
                     accel_n = 16'd0;
                  end
               end else begin
                  frame_n = frame_q + 16'd1;
               end
            end
         end

         ST_RACE: begin
            if (tick) begin
               if (time_q != 16'hFFFF) begin
                  time_n = time_q + 16'd1;
               end
               if (accel_q == ACCEL_LAST) begin
                  accel_n = 16'd0;
                  speed_n = speed_step(speed_q, throttle, SPD_MAX);
               end else begin
                  accel_n = accel_q + 16'd1;
               end
               if (pos_sum >= FINISH_POS) begin
                  xpos_n  = FINISH_POS[11:0];
                  speed_n = 4'd0;
                  state_n = ST_FINISH;
               end else begin
                  xpos_n = pos_sum[11:0];
               end
            end
         end

         ST_FINISH: begin
            if (space_press) begin
               state_n = ST_IDLE;
               xpos_n  = START_POS;
               speed_n = 4'd0;
               time_n  = 16'd0;
               cd_n    = 2'd0;
               fs_n    = 1'b0;
               frame_n = 16'd0;
               accel_n = 16'd0;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase

      mov_n = (state_n == ST_RACE) && (speed_n != 4'd0);
   end

   // Output logic: ports are straight copies of registers so draw_car and
   // the HUD only ever see values that change on clock edges.
   always_comb begin
      car_xpos    = xpos_q;
      car_ypos    = CAR_ROW;
      car_mov     = mov_q;
      state       = state_q;
      countdown   = cd_q;
      speed       = speed_q;
      race_time   = time_q;
      false_start = fs_q;
   end

endmodule

// File: tb/tb_race_ctrl.sv
// tb_race_ctrl
// Self-checking bench for race_ctrl at default parameters. A table of
// scenario steps (keys to send, frames to tick, expected outputs) drives
// the main race flow; hand-written sequences cover reset mid-race, a key
// coinciding with a tick, and a long vsync pulse.
module tb_race_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync_in;
   logic        key_valid;
   logic [7:0]  key_code;
   logic [11:0] car_xpos;
   logic [11:0] car_ypos;
   logic        car_mov;
   logic [1:0]  state;
   logic [1:0]  countdown;
   logic [3:0]  speed;
   logic [15:0] race_time;
   logic        false_start;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      int unsigned nkeys;
      logic [7:0]  key0;
      logic [7:0]  key1;
      int unsigned ticks;
      logic [1:0]  st;
      logic [1:0]  cd;
      logic [3:0]  spd;
      logic [11:0] x;
      logic [15:0] t;
      logic        mov;
      logic        fs;
   } vec_t;

   typedef struct {
      string       name;
      logic [1:0]  st;
      logic [1:0]  cd;
      logic [3:0]  spd;
      logic [11:0] x;
      logic [15:0] t;
      logic        mov;
      logic        fs;
   } exp_t;

   exp_t expQ[$];
   vec_t vecs[27];

   race_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .vsync_in    (vsync_in),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .car_xpos    (car_xpos),
      .car_ypos    (car_ypos),
      .car_mov     (car_mov),
      .state       (state),
      .countdown   (countdown),
      .speed       (speed),
      .race_time   (race_time),
      .false_start (false_start)
   );

   always #5 clk = ~clk;

   // Safety net so a stuck run still ends with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input string n, input int unsigned nk,
                               input logic [7:0] k0, input logic [7:0] k1,
                               input int unsigned tk, input logic [1:0] st,
                               input logic [1:0] cd, input logic [3:0] spd,
                               input logic [11:0] x, input logic [15:0] t,
                               input logic mov, input logic fs);
      vec_t v;
      v.name = n; v.nkeys = nk; v.key0 = k0; v.key1 = k1; v.ticks = tk;
      v.st = st; v.cd = cd; v.spd = spd; v.x = x; v.t = t; v.mov = mov; v.fs = fs;
      return v;
   endfunction

   task automatic pushExpect(input string n, input logic [1:0] st, input logic [1:0] cd,
                             input logic [3:0] spd, input logic [11:0] x,
                             input logic [15:0] t, input logic mov, input logic fs);
      exp_t e;
      e.name = n; e.st = st; e.cd = cd; e.spd = spd; e.x = x; e.t = t; e.mov = mov; e.fs = fs;
      expQ.push_back(e);
   endtask

   task automatic cycle(input logic v, input logic kv, input logic [7:0] kc);
      vsync_in  = v;
      key_valid = kv;
      key_code  = kc;
      @(posedge clk);
      #1;
      vsync_in  = 1'b0;
      key_valid = 1'b0;
      key_code  = 8'h00;
   endtask

   task automatic doTick();
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
   endtask

   task automatic sendKey(input logic [7:0] kc);
      cycle(1'b0, 1'b1, kc);
   endtask

   task automatic cmp(input string nm, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s.%s: got %0d, expected %0d", nm, field, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.nkeys > 0) sendKey(v.key0);
      if (v.nkeys > 1) sendKey(v.key1);
      for (int i = 0; i < int'(v.ticks); i++) doTick();
      pushExpect(v.name, v.st, v.cd, v.spd, v.x, v.t, v.mov, v.fs);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = expQ.pop_front();
         cmp(e.name, "state",       32'(state),       32'(e.st));
         cmp(e.name, "countdown",   32'(countdown),   32'(e.cd));
         cmp(e.name, "speed",       32'(speed),       32'(e.spd));
         cmp(e.name, "car_xpos",    32'(car_xpos),    32'(e.x));
         cmp(e.name, "race_time",   32'(race_time),   32'(e.t));
         cmp(e.name, "car_mov",     32'(car_mov),     32'(e.mov));
         cmp(e.name, "false_start", 32'(false_start), 32'(e.fs));
         cmp(e.name, "car_ypos",    32'(car_ypos),    32'd400);
      end
   endtask

   initial begin
      //                name               nk  key0   key1   ticks st cd spd  x    t   mov fs
      vecs[0]  = mk("space_to_cd",        1, 8'h29, 8'h00,   0, 1, 3, 0, 256,  0, 0, 0);
      vecs[1]  = mk("cd_tick59",          0, 8'h00, 8'h00,  59, 1, 3, 0, 256,  0, 0, 0);
      vecs[2]  = mk("cd_tick60",          0, 8'h00, 8'h00,   1, 1, 2, 0, 256,  0, 0, 0);
      vecs[3]  = mk("cd_tick179",         0, 8'h00, 8'h00, 119, 1, 1, 0, 256,  0, 0, 0);
      vecs[4]  = mk("race_entry",         0, 8'h00, 8'h00,   1, 2, 0, 0, 256,  0, 0, 0);
      vecs[5]  = mk("w_tick3",            1, 8'h1D, 8'h00,   3, 2, 0, 0, 256,  3, 0, 0);
      vecs[6]  = mk("w_tick4",            0, 8'h00, 8'h00,   1, 2, 0, 1, 256,  4, 1, 0);
      vecs[7]  = mk("w_tick5",            0, 8'h00, 8'h00,   1, 2, 0, 1, 257,  5, 1, 0);
      vecs[8]  = mk("w_tick60",           0, 8'h00, 8'h00,  55, 2, 0, 15, 676, 60, 1, 0);
      vecs[9]  = mk("w_tick64",           0, 8'h00, 8'h00,   4, 2, 0, 15, 736, 64, 1, 0);
      vecs[10] = mk("w_tick78",           0, 8'h00, 8'h00,  14, 2, 0, 15, 946, 78, 1, 0);
      vecs[11] = mk("finish_line",        0, 8'h00, 8'h00,   1, 3, 0, 0, 960, 79, 0, 0);
      vecs[12] = mk("finish_hold",        0, 8'h00, 8'h00,   5, 3, 0, 0, 960, 79, 0, 0);
      vecs[13] = mk("release_in_fin",     2, 8'hF0, 8'h1D,   0, 3, 0, 0, 960, 79, 0, 0);
      vecs[14] = mk("fin_to_idle",        1, 8'h29, 8'h00,   0, 0, 0, 0, 256,  0, 0, 0);
      vecs[15] = mk("idle_ticks",         0, 8'h00, 8'h00,   3, 0, 0, 0, 256,  0, 0, 0);
      vecs[16] = mk("cd_again",           1, 8'h29, 8'h00,  10, 1, 3, 0, 256,  0, 0, 0);
      vecs[17] = mk("w_in_cd",            1, 8'h1D, 8'h00,   0, 1, 3, 0, 256,  0, 0, 0);
      vecs[18] = mk("false_start",        0, 8'h00, 8'h00,   1, 3, 0, 0, 256,  0, 0, 1);
      vecs[19] = mk("fs_release",         2, 8'hF0, 8'h1D,   0, 3, 0, 0, 256,  0, 0, 1);
      vecs[20] = mk("fs_to_idle",         1, 8'h29, 8'h00,   0, 0, 0, 0, 256,  0, 0, 0);
      vecs[21] = mk("race3_entry",        1, 8'h29, 8'h00, 180, 2, 0, 0, 256,  0, 0, 0);
      vecs[22] = mk("race3_speed8",       1, 8'h1D, 8'h00,  32, 2, 0, 8, 368, 32, 1, 0);
      vecs[23] = mk("release_4",          2, 8'hF0, 8'h1D,   4, 2, 0, 7, 400, 36, 1, 0);
      vecs[24] = mk("release_32",         0, 8'h00, 8'h00,  28, 2, 0, 0, 512, 64, 0, 0);
      vecs[25] = mk("coast_hold",         0, 8'h00, 8'h00,   8, 2, 0, 0, 512, 72, 0, 0);
      vecs[26] = mk("space_in_race",      1, 8'h29, 8'h00,   0, 2, 0, 0, 512, 72, 0, 0);

      rst       = 1'b1;
      vsync_in  = 1'b0;
      key_valid = 1'b0;
      key_code  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      pushExpect("reset", 0, 0, 0, 256, 0, 0, 0);
      checkOutput();
      rst = 1'b0;
      cycle(1'b0, 1'b0, 8'h00);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      // Reset mid-race with W held: everything returns to the start line,
      // and the held W must be forgotten (else the next countdown fails).
      sendKey(8'h1D);
      rst = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      pushExpect("rst_mid_race", 0, 0, 0, 256, 0, 0, 0);
      checkOutput();

      sendKey(8'h29);
      for (int i = 0; i < 180; i++) doTick();
      pushExpect("rst_throttle_lost", 2, 0, 0, 256, 0, 0, 0);
      checkOutput();

      // Fourth tick (an accel step) lands on the same edge as the W make:
      // the step must use the old, released throttle.
      for (int i = 0; i < 3; i++) doTick();
      cycle(1'b1, 1'b1, 8'h1D);
      cycle(1'b0, 1'b0, 8'h00);
      pushExpect("coincident_tick", 2, 0, 0, 256, 4, 0, 0);
      checkOutput();

      for (int i = 0; i < 4; i++) doTick();
      pushExpect("after_coincident", 2, 0, 1, 256, 8, 1, 0);
      checkOutput();

      // A vsync held high for several cycles is still a single frame.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      pushExpect("long_vsync", 2, 0, 1, 257, 9, 1, 0);
      checkOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
